// File: rtl/mem_arbiter_mo_pkg.sv
// Shared helpers for the multi-outstanding memory arbiter.
//   idx_width(cnt)     : bits needed to name one of cnt masters (min 1)
//   cnt_width(max_out) : bits needed to count 0..max_out in-flight requests
package mem_arbiter_mo_pkg;

  function automatic int idx_width(input int cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_mo_if.sv
// Bus bundle for mem_arbiter_mo: CNT decoupled request/response master
// channels plus the single slave memory port.
//   master_req_*  : per-master request (valid/data in, ready out of arbiter)
//   master_resp_* : per-master response (valid/data out, ready in)
//   slave_req_*   : arbitrated request toward memory
//   slave_resp_*  : in-order responses from memory
// Modport slave is the arbiter's view; modport master is the environment
// (clients plus memory) driving it.
interface mem_arbiter_mo_if #(
  parameter int CNT        = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [CNT-1:0]                 master_req_valid;
  logic [CNT-1:0]                 master_req_ready;
  logic [CNT-1:0][ADDR_WIDTH-1:0] master_req_data;
  logic [CNT-1:0]                 master_resp_valid;
  logic [CNT-1:0]                 master_resp_ready;
  logic [CNT-1:0][DATA_WIDTH-1:0] master_resp_data;
  logic                           slave_req_valid;
  logic                           slave_req_ready;
  logic [ADDR_WIDTH-1:0]          slave_req_data;
  logic                           slave_resp_valid;
  logic                           slave_resp_ready;
  logic [DATA_WIDTH-1:0]          slave_resp_data;

  modport slave (
    input  master_req_valid, master_req_data, master_resp_ready,
    input  slave_req_ready, slave_resp_valid, slave_resp_data,
    output master_req_ready, master_resp_valid, master_resp_data,
    output slave_req_valid, slave_req_data, slave_resp_ready
  );

  modport master (
    output master_req_valid, master_req_data, master_resp_ready,
    output slave_req_ready, slave_resp_valid, slave_resp_data,
    input  master_req_ready, master_resp_valid, master_resp_data,
    input  slave_req_valid, slave_req_data, slave_resp_ready
  );
endinterface

// File: rtl/mem_arbiter_mo_prio_picker.sv
// Rotating priority picker. Searches the eligible vector starting at
// start_idx and wrapping modulo CNT; the first eligible entry wins.
//   start_idx : first index examined (tie to 0 for fixed lowest-wins)
//   elig      : eligible set
//   gnt_idx   : winning index (0 when none)
//   any       : at least one entry eligible
module mem_arbiter_mo_prio_picker
  import mem_arbiter_mo_pkg::*;
#(
  parameter int CNT = 4,
  parameter int IW  = idx_width(CNT)
) (
  input  logic [IW-1:0]  start_idx,
  input  logic [CNT-1:0] elig,
  output logic [IW-1:0]  gnt_idx,
  output logic           any
);
  logic [IW-1:0] j;

  // Walk from the lowest priority back to the highest so the last hit,
  // the one closest to start_idx, is the one that sticks.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      j = IW'((int'(start_idx) + i) % CNT);
      if (elig[j]) begin
        gnt_idx = j;
        any     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter_mo.sv
// Multi-outstanding memory arbiter: merges CNT master request streams onto
// one memory port and steers in-order responses back via a fall-through
// tag FIFO of master indices.
//   clk, rst_n : clock, async active-low reset
//   bus        : mem_arbiter_mo_if.slave (all request/response channels)
//   pending    : bit i set while master i has a request in flight
//   busy       : tag FIFO non-empty
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration
// (rr_ptr register); otherwise fixed priority, lowest index wins.
// The interface instance must use the same CNT/ADDR_WIDTH/DATA_WIDTH.
module mem_arbiter_mo
  import mem_arbiter_mo_pkg::*;
#(
  parameter int CNT             = 4,
  parameter int QUEUE_DEPTH     = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_mo_if.slave bus,
  output logic [CNT-1:0]  pending,
  output logic            busy
);
  localparam int IW = idx_width(CNT);
  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam int PW = idx_width(QUEUE_DEPTH);
  localparam int FW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] CAP      = CW'(MAX_OUTSTANDING);
  localparam logic [FW-1:0] DEPTH    = FW'(QUEUE_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH - 1);

  logic [CNT-1:0][CW-1:0]         cnt_q, cnt_d;
  logic [QUEUE_DEPTH-1:0][IW-1:0] tag_q, tag_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]                  fill_q, fill_d;
  logic                           locked_q, locked_d;
  logic [IW-1:0]                  lock_idx_q, lock_idx_d;

  logic [CNT-1:0]        elig;
  logic [IW-1:0]         start_idx, pick_idx, grant, head;
  logic                  pick_any;
  logic                  fifo_empty, fifo_full, pop_early, head_vld;
  logic                  req_fire, resp_fire;
  logic [ADDR_WIDTH-1:0] req_data;
  logic [DATA_WIDTH-1:0] resp_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // ---------------- arbitration ----------------
`ifdef MEM_ARBITER_RR_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(CNT - 1);
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  assign start_idx = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + 1'b1;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (req_fire) rr_ptr_d = grant;
  end

  // Reset to the last index so the first search starts at master 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= LAST_IDX;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  assign start_idx = '0;
`endif

  always_comb begin
    elig = '0;
    for (int i = 0; i < CNT; i++)
      elig[i] = bus.master_req_valid[i] && (cnt_q[i] < CAP);
  end

  mem_arbiter_mo_prio_picker #(.CNT(CNT), .IW(IW)) u_picker (
    .start_idx (start_idx),
    .elig      (elig),
    .gnt_idx   (pick_idx),
    .any       (pick_any)
  );

  assign grant      = locked_q ? lock_idx_q : pick_idx;
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == DEPTH);

  // A stored head retiring this cycle frees its slot for a same-cycle push.
  // Only the registered head is used here, which keeps the request path
  // independent of the bypass through an empty queue.
  assign pop_early = !fifo_empty && bus.slave_resp_valid &&
                     bus.master_resp_ready[tag_q[rd_ptr_q]];

  assign bus.slave_req_valid = rst_n && (!fifo_full || pop_early) &&
                               (locked_q || pick_any);
  assign req_data            = bus.master_req_data[grant];
  assign bus.slave_req_data  = req_data;
  assign req_fire            = bus.slave_req_valid && bus.slave_req_ready;

  // ---------------- response routing ----------------
  // Fall-through: an empty queue presents the index being pushed right now.
  assign head_vld             = !fifo_empty || req_fire;
  assign head                 = fifo_empty ? grant : tag_q[rd_ptr_q];
  assign bus.slave_resp_ready = head_vld && bus.master_resp_ready[head];
  assign resp_fire            = bus.slave_resp_valid && bus.slave_resp_ready;
  assign resp_data            = bus.slave_resp_data;

  always_comb begin
    bus.master_req_ready  = '0;
    bus.master_resp_valid = '0;
    bus.master_resp_data  = '0;
    for (int i = 0; i < CNT; i++) begin
      bus.master_req_ready[i]  = req_fire && (grant == IW'(i));
      bus.master_resp_valid[i] = head_vld && bus.slave_resp_valid &&
                                 (head == IW'(i));
      bus.master_resp_data[i]  = resp_data;
    end
  end

  // ---------------- next state ----------------
  // Hold the grant on a stalled offer; a full queue drops valid but keeps it.
  always_comb begin
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (req_fire) begin
      locked_d = 1'b0;
    end else if (bus.slave_req_valid) begin
      locked_d   = 1'b1;
      lock_idx_d = grant;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < CNT; i++)
      cnt_d[i] = cnt_q[i] + CW'(req_fire  && (grant == IW'(i)))
                          - CW'(resp_fire && (head  == IW'(i)));
  end

  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (req_fire) begin
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (resp_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    fill_d = fill_q + FW'(req_fire) - FW'(resp_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // ---------------- status ----------------
  always_comb begin
    pending = '0;
    for (int i = 0; i < CNT; i++) pending[i] = (cnt_q[i] != '0);
  end
  assign busy = !fifo_empty;

endmodule
